// File: rtl/sw_event_gen.sv
// sw_event_gen: synchronise, debounce and turn raw push-buttons into press/release/long/repeat pulses
module sw_event_gen #(
  parameter int N_SW         = 4,
  parameter int TICK_DIV     = 50000,
  parameter int DEB_TICKS    = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_press,
  output logic [N_SW-1:0] o_release,
  output logic [N_SW-1:0] o_long,
  output logic [N_SW-1:0] o_repeat,
  output logic [N_SW-1:0] o_held
);
  localparam logic [2:0]  IDLE     = 3'd0;
  localparam logic [2:0]  DEB_P    = 3'd1;
  localparam logic [2:0]  HELD     = 3'd2;
  localparam logic [2:0]  RPT      = 3'd3;
  localparam logic [2:0]  DEB_R    = 3'd4;
  localparam logic [31:0] TICK_END = 32'(TICK_DIV - 1);
  localparam logic [15:0] DEB_LIM  = 16'(DEB_TICKS);
  localparam logic [15:0] LONG_LIM = 16'(LONG_TICKS);
  localparam logic [15:0] RPT_LIM  = 16'(REPEAT_TICKS);

  logic [N_SW-1:0] s1_q, sw_s_q;
  logic [31:0]     cnt_q;
  logic            tick;

  assign tick = cnt_q == TICK_END;

  // two-flop synchroniser; flops reset to the released level so no phantom press after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q   <= '1;
      sw_s_q <= '1;
    end else begin
      s1_q   <= i_sw;
      sw_s_q <= s1_q;
    end

  // shared sample-tick divider, wraps at TICK_DIV-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + 32'd1;

  for (genvar g = 0; g < N_SW; g++) begin : ch
    logic [2:0]  state_q, state_d;
    logic        org_q, org_d;
    logic [15:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d, dinc, hinc;
    logic        press_q, press_d, rel_q, rel_d, long_q, long_d, rpt_q, rpt_d, held_q, held_d;
    logic        s;

    assign s    = sw_s_q[g];
    assign dinc = dcnt_q + 16'd1;
    assign hinc = hcnt_q + 16'd1;

    // per-channel next state; org_q remembers whether a release bounce came from HELD or RPT
    always_comb begin
      state_d = state_q;
      org_d   = org_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      if (tick)
        case (state_q)
          IDLE: if (!s) begin
            state_d = DEB_P;
            dcnt_d  = 16'd1;
          end
          DEB_P: if (!s) begin
            dcnt_d = dinc;
            if (dinc == DEB_LIM) begin
              state_d = HELD;
              dcnt_d  = '0;
              hcnt_d  = '0;
              press_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
            dcnt_d  = '0;
          end
          HELD: if (!s) begin
            hcnt_d = hinc;
            if (hinc == LONG_LIM) begin
              state_d = RPT;
              hcnt_d  = '0;
              long_d  = 1'b1;
            end
          end else begin
            state_d = DEB_R;
            dcnt_d  = 16'd1;
            org_d   = 1'b0;
          end
          RPT: if (!s) begin
            hcnt_d = hinc;
            if (hinc == RPT_LIM) begin
              hcnt_d = '0;
              rpt_d  = 1'b1;
            end
          end else begin
            state_d = DEB_R;
            dcnt_d  = 16'd1;
            org_d   = 1'b1;
          end
          DEB_R: if (s) begin
            dcnt_d = dinc;
            if (dinc == DEB_LIM) begin
              state_d = IDLE;
              dcnt_d  = '0;
              hcnt_d  = '0;
              rel_d   = 1'b1;
            end
          end else begin
            state_d = org_q ? RPT : HELD;
            dcnt_d  = '0;
          end
          default: begin
            state_d = IDLE;
            dcnt_d  = '0;
            hcnt_d  = '0;
          end
        endcase
      held_d = (state_d == HELD) | (state_d == RPT) | (state_d == DEB_R);
    end

    // state, counters and registered outputs; pulses self-clear on the next non-tick cycle
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state_q <= IDLE;
        org_q   <= 1'b0;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        org_q   <= org_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
        held_q  <= held_d;
      end

    assign o_press[g]   = press_q;
    assign o_release[g] = rel_q;
    assign o_long[g]    = long_q;
    assign o_repeat[g]  = rpt_q;
    assign o_held[g]    = held_q;
  end
endmodule

// File: tb/tb_sw_event_gen.sv
// tb_sw_event_gen: directed tick-by-tick checks of sw_event_gen pulses and held level
module tb_sw_event_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_sw;
  logic [3:0] o_press, o_release, o_long, o_repeat, o_held;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tk = 0;
  string      phase = "reset";

  sw_event_gen #(
    .N_SW(4), .TICK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(5), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(i_sw),
    .o_press(o_press), .o_release(o_release), .o_long(o_long),
    .o_repeat(o_repeat), .o_held(o_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s tick%0d %s: got %h expected %h", phase, tk, tag, got, exp);
    end
  endtask

  // advance one sample tick: pulses must stay low on the three off-tick cycles, then check the tick result
  task automatic step(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] rp, input logic [3:0] h);
    tk++;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("gap", o_press | o_release | o_long | o_repeat, 4'h0);
    end
    @(posedge clk);
    #1;
    chk("press", o_press, p);
    chk("release", o_release, r);
    chk("long", o_long, l);
    chk("repeat", o_repeat, rp);
    chk("held", o_held, h);
  endtask

  initial begin
    rst_n = 1'b0;
    i_sw  = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_press", o_press, 4'h0);
    chk("rst_release", o_release, 4'h0);
    chk("rst_long", o_long, 4'h0);
    chk("rst_repeat", o_repeat, 4'h0);
    chk("rst_held", o_held, 4'h0);
    rst_n = 1'b1;
    phase = "idle";
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    phase = "long_repeat";
    tk = 0;
    i_sw[0] = 1'b0;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    repeat (4) step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h1, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h0, 4'h1, 4'h1);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h0, 4'h1, 4'h1);
    i_sw[0] = 1'b1;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    phase = "glitch";
    tk = 0;
    i_sw[1] = 1'b0;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    i_sw[1] = 1'b1;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    phase = "bounce";
    tk = 0;
    i_sw[2] = 1'b0;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h4, 4'h0, 4'h0, 4'h0, 4'h4);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
    i_sw[2] = 1'b1;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
    i_sw[2] = 1'b0;
    repeat (3) step(4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
    step(4'h0, 4'h0, 4'h4, 4'h0, 4'h4);
    i_sw[2] = 1'b1;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
    step(4'h0, 4'h4, 4'h0, 4'h0, 4'h0);

    phase = "simultaneous";
    tk = 0;
    i_sw[0] = 1'b0;
    i_sw[3] = 1'b0;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h9, 4'h0, 4'h0, 4'h0, 4'h9);
    i_sw[0] = 1'b1;
    i_sw[3] = 1'b1;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h9);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h9);
    step(4'h0, 4'h9, 4'h0, 4'h0, 4'h0);

    phase = "mid_reset";
    tk = 0;
    i_sw[0] = 1'b0;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    repeat (4) step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h1, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_held", o_held, 4'h0);
    chk("async_pulses", o_press | o_release | o_long | o_repeat, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    phase = "after_reset";
    tk = 0;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    i_sw[0] = 1'b1;
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    step(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
